// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
// State encoding, PC increment and default reset vector.
package fetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DRAIN  = 3'd2,
      S_VALID  = 3'd3,
      S_HALTED = 3'd4
   } fetch_state_t;

   localparam logic [31:0] PC_STEP              = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - fetch program counter register
// Async active-high reset to RESET_VECTOR, loads i_next when i_load is set.
import fetch_pkg::*;

module fetch_pc_reg #(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic [31:0] i_next,
   output logic [31:0] o_pc
);

   logic [31:0] r_pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc <= RESET_VECTOR;
      end else if (i_load) begin
         r_pc <= i_next;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with redirect, drain and halt
// Optional FETCH_MISALIGN_TRAP_EN sends misaligned redirects to i_trap_vector.
import fetch_pkg::*;

module fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic        clk,
   input  logic        reset,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   input  logic        i_core_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_halt,
   input  logic [31:0] i_trap_vector,
   output logic        o_misalign_trap,
   output logic [31:0] o_pc
);

   fetch_state_t r_state;
   logic         r_imem_req;
   logic         r_instr_valid;
   logic [31:0]  r_instr;
   logic [31:0]  r_instr_pc;
   logic [31:0]  r_drain_addr;
   logic         r_misalign_trap;

   logic [31:0]  w_pc;
   logic         w_pc_load;
   logic [31:0]  w_pc_next;
   logic         w_misaligned;
   logic [31:0]  w_redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign w_misaligned      = |i_redirect_pc[1:0];
   assign w_redirect_target = w_misaligned ? i_trap_vector : i_redirect_pc;
`else
   logic w_unused;
   assign w_misaligned      = 1'b0;
   assign w_redirect_target = {i_redirect_pc[31:2], 2'b00};
   assign w_unused          = ^{i_trap_vector, i_redirect_pc[1:0]};
`endif

   // A redirect always retargets the PC; otherwise the PC only advances on an accepted fetch.
   always_comb begin
      w_pc_load = 1'b0;
      w_pc_next = w_pc + PC_STEP;
      if (i_redirect) begin
         w_pc_load = 1'b1;
         w_pc_next = w_redirect_target;
      end else if (r_state == S_FETCH && i_imem_ack) begin
         w_pc_load = 1'b1;
      end
   end

   fetch_pc_reg #(
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc_reg (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_pc_load),
      .i_next (w_pc_next),
      .o_pc   (w_pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_imem_req      <= 1'b0;
         r_instr_valid   <= 1'b0;
         r_instr         <= 32'd0;
         r_instr_pc      <= 32'd0;
         r_drain_addr    <= RESET_VECTOR;
         r_misalign_trap <= 1'b0;
      end else begin
         r_misalign_trap <= i_redirect & w_misaligned;
         case (r_state)
            S_IDLE: begin
               r_state    <= S_FETCH;
               r_imem_req <= 1'b1;
            end
            S_FETCH: begin
               if (i_redirect) begin
                  // Without an ack the old request is still outstanding and must be drained.
                  if (!i_imem_ack) begin
                     r_state      <= S_DRAIN;
                     r_drain_addr <= w_pc;
                  end
               end else if (i_imem_ack) begin
                  r_instr       <= i_imem_rdata;
                  r_instr_pc    <= w_pc;
                  r_instr_valid <= 1'b1;
                  r_imem_req    <= 1'b0;
                  r_state       <= S_VALID;
               end
            end
            S_DRAIN: begin
               if (i_imem_ack) begin
                  r_state <= S_FETCH;
               end
            end
            S_VALID: begin
               if (i_redirect) begin
                  r_instr_valid <= 1'b0;
                  r_imem_req    <= 1'b1;
                  r_state       <= S_FETCH;
               end else if (i_core_ready) begin
                  r_instr_valid <= 1'b0;
                  if (i_halt) begin
                     r_state <= S_HALTED;
                  end else begin
                     r_imem_req <= 1'b1;
                     r_state    <= S_FETCH;
                  end
               end
            end
            S_HALTED: begin
               if (i_redirect) begin
                  r_imem_req <= 1'b1;
                  r_state    <= S_FETCH;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_imem_req    <= 1'b0;
               r_instr_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_imem_req      = r_imem_req;
   assign o_imem_addr     = (r_state == S_DRAIN) ? r_drain_addr : w_pc;
   assign o_instr_valid   = r_instr_valid;
   assign o_instr         = r_instr;
   assign o_instr_pc      = r_instr_pc;
   assign o_misalign_trap = r_misalign_trap;
   assign o_pc            = w_pc;

endmodule
